// File: rtl/bias_relu_sequencer.sv
// Per-pixel bias add, saturation and optional ReLU over a stream of accumulator beats.
// The layer pass is sequenced by an IDLE/RUN/DRAIN/DONE FSM feeding a two-stage stallable pipeline.
module bias_relu_sequencer #(
  parameter int unsigned NUM_CH = 112,
  parameter int unsigned ACC_W  = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [15:0]         num_pix,
  input  logic                relu_en,
  input  logic [16*NUM_CH-1:0] bias_mem,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ACC_W-1:0]    acc_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         out_data,
  output logic [6:0]          out_ch,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [6:0] CH_LAST = 7'(NUM_CH - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(32767);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-32768);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, next_state;

  logic [6:0]  ch;
  logic [15:0] pix;
  logic [15:0] num_pix_q;
  logic        relu_q;
  logic        en, accept, last_beat;

  logic                    s1_valid, s1_last;
  logic signed [ACC_W-1:0] s1_acc;
  logic [6:0]              s1_ch;
  logic signed [16:0]      s1_bias;

  logic [15:0]             bias_arr [NUM_CH];
  logic [15:0]             bias_raw;
  logic signed [16:0]      bias_mag, bias_c;
  logic signed [SUM_W-1:0] sum_c;
  logic [15:0]             res_c;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_bias
    assign bias_arr[i] = bias_mem[16*i +: 16];
  end

  assign en        = !out_valid || out_ready;
  assign in_ready  = (state == RUN) && en;
  assign accept    = in_valid && in_ready;
  assign last_beat = (ch == CH_LAST) && (pix == num_pix_q - 16'd1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (num_pix != 16'd0) ? RUN : DONE;
      RUN:     if (accept && last_beat) next_state = DRAIN;
      DRAIN:   if (!s1_valid && !out_valid) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Pass parameters, channel/pixel counters and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch        <= '0;
      pix       <= '0;
      num_pix_q <= '0;
      relu_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= (next_state != IDLE);
      done <= (next_state == DONE);
      if (state == IDLE && start) begin
        num_pix_q <= num_pix;
        relu_q    <= relu_en;
        ch        <= '0;
        pix       <= '0;
      end else if (accept) begin
        if (ch == CH_LAST) begin
          ch  <= '0;
          pix <= pix + 16'd1;
        end else begin
          ch <= ch + 7'd1;
        end
      end
    end
  end

  // Sign-magnitude bias to two's complement; negative zero falls out as 0
  always_comb begin
    bias_raw = bias_arr[ch];
    bias_mag = $signed({2'b00, bias_raw[14:0]});
    bias_c   = bias_raw[15] ? -bias_mag : bias_mag;
  end

  // Widened add, saturate to 16 bits, then optional ReLU
  always_comb begin
    sum_c = SUM_W'(s1_acc) + SUM_W'(s1_bias);
    if (sum_c > SAT_MAX)      res_c = 16'h7FFF;
    else if (sum_c < SAT_MIN) res_c = 16'h8000;
    else                      res_c = sum_c[15:0];
    if (relu_q && res_c[15])  res_c = 16'h0000;
  end

  // Two pipeline stages sharing one enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_acc    <= '0;
      s1_ch     <= '0;
      s1_bias   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end else if (en) begin
      s1_valid  <= accept;
      if (accept) begin
        s1_acc  <= acc_in;
        s1_ch   <= ch;
        s1_last <= last_beat;
        s1_bias <= bias_c;
      end
      out_valid <= s1_valid;
      out_last  <= s1_valid && s1_last;
      if (s1_valid) begin
        out_data <= res_c;
        out_ch   <= s1_ch;
      end
    end
  end

endmodule

// File: tb/tb_bias_relu_sequencer.sv
// Directed, table-driven bench for bias_relu_sequencer with a scoreboard model of the bias/saturate/ReLU path.
module tb_bias_relu_sequencer;

  localparam int unsigned NUM_CH = 112;
  localparam int unsigned ACC_W  = 24;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [15:0]          num_pix;
  logic                 relu_en;
  logic [16*NUM_CH-1:0] bias_mem;
  logic                 in_valid;
  logic                 in_ready;
  logic [ACC_W-1:0]     acc_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [15:0]          out_data;
  logic [6:0]           out_ch;
  logic                 out_last;
  logic                 busy;
  logic                 done;

  bias_relu_sequencer #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_pix(num_pix), .relu_en(relu_en),
    .bias_mem(bias_mem), .in_valid(in_valid), .in_ready(in_ready), .acc_in(acc_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int acc_tab [0:1023];
  logic [15:0] rx_data [0:1023];

  typedef struct {
    int          ch;
    logic [15:0] bias;
    int          acc;
    bit          relu;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [15:0] model(input int acc, input logic [15:0] b, input bit relu);
    longint bv, s;
    bv = longint'(b[14:0]);
    if (b[15]) bv = -bv;
    s = longint'(acc) + bv;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return 16'(s);
  endfunction

  // Runs one pass; abort_at >= 0 returns after that many accepted beats without finishing.
  task automatic run_pass(input int npix, input bit relu, input int rdy_pct, input int abort_at);
    int total, sent, rcvd, cyc, budget, done_cyc, last_out_cyc;
    int lat_bad, hold_bad, last_cnt, last_pos, mism, chm;
    int acc_cyc_q[$];
    logic [15:0] exp_d_q[$];
    logic [6:0]  exp_ch_q[$];
    bit          exp_last_q[$];
    logic        prev_stall;
    logic [15:0] prev_data;
    logic [6:0]  prev_ch;
    logic        prev_last;
    logic [15:0] ed;
    logic [6:0]  ec;
    bit          el;
    total = npix * int'(NUM_CH);
    sent = 0; rcvd = 0; cyc = 0; done_cyc = -1; last_out_cyc = -1;
    lat_bad = 0; hold_bad = 0; last_cnt = 0; last_pos = -1; mism = 0;
    budget = total * 6 + 60;
    prev_stall = 1'b0; prev_data = '0; prev_ch = '0; prev_last = 1'b0;

    @(negedge clk);
    start = 1'b1; num_pix = 16'(npix); relu_en = relu;
    @(negedge clk);
    num_pix = 16'hFFFF;
    relu_en = !relu;
    while (cyc < budget) begin
      start     = (cyc == 10);
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      in_valid  = (sent < total) && ($urandom_range(0, 99) < 80);
      acc_in    = in_valid ? 24'(acc_tab[sent]) : 24'h5A5A5A;
      #1;
      if (prev_stall && (!out_valid || out_data !== prev_data || out_ch !== prev_ch || out_last !== prev_last))
        hold_bad++;
      if (out_valid && out_ready) begin
        if (exp_d_q.size() == 0) mism++;
        else begin
          ed = exp_d_q.pop_front(); ec = exp_ch_q.pop_front(); el = exp_last_q.pop_front();
          if (out_data !== ed || out_ch !== ec || out_last !== el) mism++;
          if (rdy_pct >= 100 && cyc - acc_cyc_q.pop_front() != 2) lat_bad++;
        end
        if (rcvd < 1024) rx_data[rcvd] = out_data;
        if (out_last) begin last_cnt++; last_pos = rcvd; end
        rcvd++;
        last_out_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data; prev_ch = out_ch; prev_last = out_last;
      if (in_valid && in_ready) begin
        chm = sent % int'(NUM_CH);
        exp_d_q.push_back(model(acc_tab[sent], bias_mem[16*chm +: 16], relu));
        exp_ch_q.push_back(7'(chm));
        exp_last_q.push_back(sent == total - 1);
        acc_cyc_q.push_back(cyc);
        sent++;
      end
      if (done) begin done_cyc = cyc; break; end
      if (abort_at >= 0 && sent == abort_at) break;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (abort_at >= 0) begin
      chk("abort_reached", sent, abort_at);
    end else begin
      in_valid = 1'b0;
      chk("beats_out", rcvd, total);
      chk("beat_mismatch", mism, 0);
      chk("hold_while_stalled", hold_bad, 0);
      chk("last_count", last_cnt, 1);
      chk("last_position", last_pos, total - 1);
      chk("done_timing", done_cyc, last_out_cyc + 2);
      if (rdy_pct >= 100) chk("latency", lat_bad, 0);
      @(negedge clk); #1;
      chk("done_one_cycle", done, 0);
      chk("busy_after", busy, 0);
    end
  endtask

  initial begin
    vecs[0] = '{0,   16'h00CF, 100,       1'b0, 16'd307};
    vecs[1] = '{1,   16'h812F, 200,       1'b0, 16'hFF99};
    vecs[2] = '{1,   16'h812F, 200,       1'b1, 16'h0000};
    vecs[3] = '{5,   16'h00FF, 8388352,   1'b0, 16'h7FFF};
    vecs[4] = '{7,   16'h8001, -8388608,  1'b0, 16'h8000};
    vecs[5] = '{3,   16'h8000, -5,        1'b0, 16'hFFFB};
    vecs[6] = '{111, 16'h7FFF, 1,         1'b0, 16'h7FFF};
    vecs[7] = '{2,   16'h0000, -32769,    1'b0, 16'h8000};
    vecs[8] = '{4,   16'h8005, 3,         1'b1, 16'h0000};
    vecs[9] = '{6,   16'h0010, 32751,     1'b0, 16'h7FFF};

    rst_n = 1'b1; start = 1'b0; num_pix = '0; relu_en = 1'b0; bias_mem = '0;
    in_valid = 1'b0; acc_in = '0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {out_valid, out_last, busy, done, in_ready, out_data, out_ch}, 0);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      bias_mem = '0;
      for (int i = 0; i < int'(NUM_CH); i++) acc_tab[i] = 0;
      bias_mem[16*vecs[v].ch +: 16] = vecs[v].bias;
      acc_tab[vecs[v].ch] = vecs[v].acc;
      run_pass(1, vecs[v].relu, 100, -1);
      chk($sformatf("vec%0d_data", v), rx_data[vecs[v].ch], vecs[v].exp);
    end

    for (int i = 0; i < int'(NUM_CH); i++) bias_mem[16*i +: 16] = 16'($urandom);
    for (int i = 0; i < 1024; i++)
      acc_tab[i] = (i % 4 == 0) ? int'($urandom_range(0, 16777215)) - 8388608
                                : int'($urandom_range(0, 80000)) - 40000;
    run_pass(2, 1'b0, 100, -1);
    run_pass(3, 1'b1, 50, -1);

    run_pass(2, 1'b0, 70, 50);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midpass_reset_outputs", {out_valid, out_last, busy, done, in_ready, out_data, out_ch}, 0);
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk); #1;
      chk("reset_hold_quiet", {out_valid, in_ready, busy}, 0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("post_reset_quiet", {out_valid, in_ready, busy, done}, 0);
    end
    in_valid = 1'b0;
    run_pass(1, 1'b1, 100, -1);

    @(negedge clk);
    start = 1'b1; num_pix = 16'd0;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("zero_len_done", done, 1);
    chk("zero_len_busy", busy, 1);
    chk("zero_len_no_out", out_valid, 0);
    @(negedge clk); #1;
    chk("zero_len_done_clear", {done, busy, out_valid}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
